// File: rtl/watch_pkg.sv
// watch_pkg
//   Shared definitions for the watch datapath and its controlling FSM:
//   - bcd_t:         one BCD digit (4 bits)
//   - mmss_t:        a full mm:ss value as four BCD digits
//   - *_MAX:         rollover value of each stopwatch digit
//   - watch_state_t: watch_fsm mode encodings
package watch_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t m_t;
    bcd_t m_u;
    bcd_t s_t;
    bcd_t s_u;
  } mmss_t;

  localparam bcd_t SEC_U_MAX = 4'd9;
  localparam bcd_t SEC_T_MAX = 4'd5;
  localparam bcd_t MIN_U_MAX = 4'd9;
  localparam bcd_t MIN_T_MAX = 4'd5;

  typedef enum logic [1:0] {
    NORMAL     = 2'b00,
    SET_TIME   = 2'b01,
    SET_ALARM  = 2'b10,
    STOP_WATCH = 2'b11
  } watch_state_t;

endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter
//   Single BCD digit that counts 0..MAX and wraps to 0. Chained through
//   carry so a whole mm:ss field ripples in one cycle.
//   Ports:
//     clk   - system clock
//     rst   - synchronous active-high reset (q -> 0)
//     clr   - synchronous clear (q -> 0), below rst in priority
//     inc   - advance this digit by one on the next edge
//     q     - current digit value (registered)
//     carry - combinational: inc while q is at MAX (next digit advances)
module bcd_digit_counter
  import watch_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);

  logic at_max;

  // >= rather than == keeps the digit self-correcting back into range.
  assign at_max = (q >= MAX);
  assign carry  = inc && at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= at_max ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core
//   BCD stopwatch datapath behind watch_fsm. Counts enabled seconds
//   00:00..59:59 with wrap-around and supports a split (lap) freeze where
//   the display holds a captured value while the live count keeps running.
//   Parameters:
//     TICK_DIV     - enabled clock cycles per stopwatch second (>= 1)
//   Ports:
//     clk          - system clock
//     rst          - synchronous active-high reset
//     en_sec_sw    - count enable (1 = running)
//     save_split   - split request level; rising edge captures the live value
//     clr          - synchronous stopwatch clear pulse
//     swm_t..sws_u - live BCD digits mm:ss (registered)
//     disp_*       - displayed digits: split value while split_active, else live
//     split_active - display frozen on split value (registered)
//     wrap         - one-cycle pulse after the 59:59 -> 00:00 rollover
module stopwatch_core
  import watch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_sec_sw,
  input  logic       save_split,
  input  logic       clr,
  output logic [3:0] swm_t,
  output logic [3:0] swm_u,
  output logic [3:0] sws_t,
  output logic [3:0] sws_u,
  output logic [3:0] disp_m_t,
  output logic [3:0] disp_m_u,
  output logic [3:0] disp_s_t,
  output logic [3:0] disp_s_u,
  output logic       split_active,
  output logic       wrap
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          step;
  logic          c_s_u;
  logic          c_s_t;
  logic          c_m_u;
  logic          c_m_t;
  logic          save_split_q;
  logic          split_rise;
  mmss_t         split_q;
  mmss_t         live;
  mmss_t         disp;

  // Prescaler: advances only on enabled cycles, so the phase is kept
  // across stop intervals. With TICK_DIV = 1 it stays at 0 and every
  // enabled cycle is a step.
  assign step = en_sec_sw && (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      presc <= '0;
    end else if (en_sec_sw) begin
      presc <= step ? '0 : presc + 1'b1;
    end
  end

  bcd_digit_counter #(.MAX(SEC_U_MAX)) u_sec_u (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (step),
    .q     (sws_u),
    .carry (c_s_u)
  );

  bcd_digit_counter #(.MAX(SEC_T_MAX)) u_sec_t (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (c_s_u),
    .q     (sws_t),
    .carry (c_s_t)
  );

  bcd_digit_counter #(.MAX(MIN_U_MAX)) u_min_u (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (c_s_t),
    .q     (swm_u),
    .carry (c_m_u)
  );

  bcd_digit_counter #(.MAX(MIN_T_MAX)) u_min_t (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (c_m_u),
    .q     (swm_t),
    .carry (c_m_t)
  );

  // Carry out of the top digit is exactly the 59:59 -> 00:00 step.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wrap <= 1'b0;
    end else begin
      wrap <= c_m_t;
    end
  end

  assign live       = {swm_t, swm_u, sws_t, sws_u};
  assign split_rise = save_split && !save_split_q;

  // save_split_q keeps sampling during clr so that a level still held
  // high afterwards is not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      save_split_q <= 1'b0;
      split_q      <= '0;
      split_active <= 1'b0;
    end else if (clr) begin
      save_split_q <= save_split;
      split_q      <= '0;
      split_active <= 1'b0;
    end else begin
      save_split_q <= save_split;
      if (split_rise) begin
        // Captures the pre-increment value when a step lands on this edge.
        split_q      <= live;
        split_active <= 1'b1;
      end else if (!save_split) begin
        split_active <= 1'b0;
      end
    end
  end

  always_comb begin
    disp = live;
    if (split_active) begin
      disp = split_q;
    end
  end

  assign disp_m_t = disp.m_t;
  assign disp_m_u = disp.m_u;
  assign disp_s_t = disp.s_t;
  assign disp_s_u = disp.s_u;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core
//   Two instances (TICK_DIV = 1 and 4) share one stimulus stream. A
//   seconds-based reference model predicts every cycle's outputs into a
//   queue per instance; the queue is popped and compared after each edge.
//   A vector table walks the main scenarios with fixed expected values,
//   followed by a hand-written prescaler-phase sequence and a random run.
module tb_stopwatch_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_sec_sw = 1'b0;
  logic save_split = 1'b0;
  logic clr = 1'b0;

  logic [3:0] a_swm_t, a_swm_u, a_sws_t, a_sws_u;
  logic [3:0] a_dm_t, a_dm_u, a_ds_t, a_ds_u;
  logic       a_split, a_wrap;
  logic [3:0] b_swm_t, b_swm_u, b_sws_t, b_sws_u;
  logic [3:0] b_dm_t, b_dm_u, b_ds_t, b_ds_u;
  logic       b_split, b_wrap;

  always #5 clk = ~clk;

  stopwatch_core #(.TICK_DIV(1)) dut_a (
    .clk(clk), .rst(rst), .en_sec_sw(en_sec_sw), .save_split(save_split), .clr(clr),
    .swm_t(a_swm_t), .swm_u(a_swm_u), .sws_t(a_sws_t), .sws_u(a_sws_u),
    .disp_m_t(a_dm_t), .disp_m_u(a_dm_u), .disp_s_t(a_ds_t), .disp_s_u(a_ds_u),
    .split_active(a_split), .wrap(a_wrap)
  );

  stopwatch_core #(.TICK_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .en_sec_sw(en_sec_sw), .save_split(save_split), .clr(clr),
    .swm_t(b_swm_t), .swm_u(b_swm_u), .sws_t(b_sws_t), .sws_u(b_sws_u),
    .disp_m_t(b_dm_t), .disp_m_u(b_dm_u), .disp_s_t(b_ds_t), .disp_s_u(b_ds_u),
    .split_active(b_split), .wrap(b_wrap)
  );

  typedef struct packed {
    logic [15:0] live;
    logic [15:0] disp;
    logic        act;
    logic        wrap;
  } out_t;

  typedef struct {
    int secs;
    int presc;
    int split_secs;
    bit split_act;
    bit ssq;
    bit wrap;
  } mstate_t;

  typedef struct {
    bit          r, c, e, s;
    int          n;
    logic [15:0] live, disp;
    bit          act, wrap;
  } vec_t;

  int checks = 0;
  int failures = 0;
  mstate_t ma, mb;
  out_t qa[$];
  out_t qb[$];
  vec_t tbl[17];

  out_t out_a, out_b;
  assign out_a = '{live: {a_swm_t, a_swm_u, a_sws_t, a_sws_u},
                   disp: {a_dm_t, a_dm_u, a_ds_t, a_ds_u}, act: a_split, wrap: a_wrap};
  assign out_b = '{live: {b_swm_t, b_swm_u, b_sws_t, b_sws_u},
                   disp: {b_dm_t, b_dm_u, b_ds_t, b_ds_u}, act: b_split, wrap: b_wrap};

  function automatic logic [15:0] to_bcd(int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic out_t expect_of(mstate_t s);
    out_t o;
    o.live = to_bcd(s.secs);
    o.disp = s.split_act ? to_bcd(s.split_secs) : o.live;
    o.act  = s.split_act;
    o.wrap = s.wrap;
    return o;
  endfunction

  function automatic mstate_t mstep(mstate_t s, int div, bit r, bit c, bit e, bit ss);
    mstate_t n = s;
    bit tick;
    if (r) begin
      n = '{0, 0, 0, 1'b0, 1'b0, 1'b0};
    end else if (c) begin
      n = '{0, 0, 0, 1'b0, ss, 1'b0};
    end else begin
      tick = e && (s.presc == div - 1);
      n.wrap = 1'b0;
      if (e) n.presc = tick ? 0 : s.presc + 1;
      if (tick) begin
        if (s.secs == 3599) begin
          n.secs = 0;
          n.wrap = 1'b1;
        end else begin
          n.secs = s.secs + 1;
        end
      end
      if (ss && !s.ssq) begin
        n.split_secs = s.secs;
        n.split_act  = 1'b1;
      end else if (!ss) begin
        n.split_act = 1'b0;
      end
      n.ssq = ss;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit c, input bit e, input bit s);
    out_t ea, eb;
    rst = r; clr = c; en_sec_sw = e; save_split = s;
    ma = mstep(ma, 1, r, c, e, s);
    qa.push_back(expect_of(ma));
    mb = mstep(mb, 4, r, c, e, s);
    qb.push_back(expect_of(mb));
    @(posedge clk);
    #1;
    if (qa.size() == 0 || qb.size() == 0) begin
      check("sb_empty", 34'd1, 34'd0);
    end else begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      check("sb_div1", out_a, ea);
      check("sb_div4", out_b, eb);
    end
  endtask

  initial begin
    ma = '{0, 0, 0, 1'b0, 1'b0, 1'b0};
    mb = ma;
    //            r  c  e  s  n     live      disp      act wrap
    tbl[0]  = '{1, 0, 1, 0, 1,    16'h0000, 16'h0000, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 75,   16'h0115, 16'h0115, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 3524, 16'h5959, 16'h5959, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 1,    16'h0000, 16'h0000, 0, 1};
    tbl[4]  = '{0, 0, 1, 0, 1,    16'h0001, 16'h0001, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, 9,    16'h0010, 16'h0010, 0, 0};
    tbl[6]  = '{0, 0, 1, 1, 15,   16'h0025, 16'h0010, 1, 0};
    tbl[7]  = '{0, 0, 1, 0, 1,    16'h0026, 16'h0026, 0, 0};
    tbl[8]  = '{0, 0, 1, 0, 4,    16'h0030, 16'h0030, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 5,    16'h0030, 16'h0030, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 1,    16'h0030, 16'h0030, 1, 0};
    tbl[11] = '{0, 1, 0, 1, 1,    16'h0000, 16'h0000, 0, 0};
    tbl[12] = '{0, 0, 1, 1, 3,    16'h0003, 16'h0003, 0, 0};
    tbl[13] = '{0, 0, 1, 0, 1,    16'h0004, 16'h0004, 0, 0};
    tbl[14] = '{0, 0, 1, 1, 1,    16'h0005, 16'h0004, 1, 0};
    tbl[15] = '{1, 0, 1, 1, 1,    16'h0000, 16'h0000, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 1,    16'h0000, 16'h0000, 0, 0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < tbl[i].n; k++) cycle(tbl[i].r, tbl[i].c, tbl[i].e, tbl[i].s);
      check($sformatf("vec%0d_live", i), {18'd0, out_a.live}, {18'd0, tbl[i].live});
      check($sformatf("vec%0d_disp", i), {18'd0, out_a.disp}, {18'd0, tbl[i].disp});
      check($sformatf("vec%0d_act", i), {33'd0, out_a.act}, {33'd0, tbl[i].act});
      check($sformatf("vec%0d_wrap", i), {33'd0, out_a.wrap}, {33'd0, tbl[i].wrap});
    end

    // Wrap pulse must drop again on the cycle after it fires.
    for (int k = 0; k < 3599; k++) cycle(0, 0, 1, 0);
    check("pre_wrap_live", {18'd0, out_a.live}, {18'd0, 16'h5959});
    cycle(0, 0, 1, 0);
    check("wrap_high", {33'd0, out_a.wrap}, 34'd1);
    cycle(0, 0, 0, 0);
    check("wrap_low", {33'd0, out_a.wrap}, 34'd0);

    // Prescaler phase held across a disabled gap (TICK_DIV = 4 instance).
    cycle(1, 0, 1, 0);
    for (int k = 0; k < 8; k++) cycle(0, 0, 1, 0);
    check("div4_8en", {18'd0, out_b.live}, {18'd0, 16'h0002});
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 0);
    check("div4_3en", {18'd0, out_b.live}, {18'd0, 16'h0002});
    for (int k = 0; k < 2; k++) cycle(0, 0, 0, 0);
    check("div4_gap", {18'd0, out_b.live}, {18'd0, 16'h0002});
    cycle(0, 0, 1, 0);
    check("div4_4th", {18'd0, out_b.live}, {18'd0, 16'h0003});
    check("div1_12en", {18'd0, out_a.live}, {18'd0, 16'h0012});

    // Random mix of enable, split, clear and occasional reset.
    begin
      bit s = 1'b0;
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(0, 7) == 0) s = ~s;
        cycle($urandom_range(0, 149) == 0, $urandom_range(0, 59) == 0,
              $urandom_range(0, 3) != 0, s);
      end
    end

    check("sb_drained", {32'd0, 2'(qa.size())}, 34'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
